// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
// Receiving end of the WB-stage commit/debug trace. Every retired instruction
// (pc != 0 and WB not stalled) is captured into a FIFO and drained to a trace
// consumer over a valid/ready handshake. Counts retirements and drops.
//
// Optional build macro: TRACE_WRONLY_EN -- when defined, only retires that
// write a register (we=1 after x0 masking) are queued; the rest still count
// as retires but never occupy or overflow the FIFO.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   wb_stall             WB entry held; not a new retirement
//   clear                synchronous flush of FIFO contents
//   debug_wb_*           WB commit trace (pc, rf_we, rf_wnum, rf_wdata)
//   trace_valid/ready    head-entry handshake to the consumer
//   trace_pc/we/wnum/wdata  head entry payload (0 when empty)
//   fifo_count           occupancy, 0..DEPTH
//   overflow             sticky: at least one retire dropped
//   drop_cnt             dropped retires, saturating
//   retire_cnt           all retires seen, dropped or not (wraps)
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_stall,
  input  logic                     clear,
  input  logic [63:0]              debug_wb_pc,
  input  logic [7:0]               debug_wb_rf_we,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [63:0]              debug_wb_rf_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [63:0]              trace_pc,
  output logic                     trace_we,
  output logic [4:0]               trace_wnum,
  output logic [63:0]              trace_wdata,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [63:0]              retire_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        we;
    logic [4:0]  wnum;
    logic [63:0] wdata;
    logic [63:0] pc;
  } trace_ent_t;

  trace_ent_t    mem [DEPTH];
  trace_ent_t    new_ent, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          retire, wr_we, enq, full, empty, push, pop, drop;

  // Replicated write enables: only bit 0 carries information.
  logic unused_rf_we;
  assign unused_rf_we = ^debug_wb_rf_we[7:1];

  assign retire = (debug_wb_pc != 64'd0) && !wb_stall;
  assign wr_we  = debug_wb_rf_we[0] && (debug_wb_rf_wnum != 5'd0);

`ifdef TRACE_WRONLY_EN
  assign enq = retire && wr_we;
`else
  assign enq = retire;
`endif

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && trace_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = enq && (!full || pop);
  // A flush cycle discards everything, so it never counts as a drop.
  assign drop  = enq && full && !pop && !clear;

  assign new_ent = '{we: wr_we, wnum: debug_wb_rf_wnum,
                     wdata: debug_wb_rf_wdata, pc: debug_wb_pc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      if (retire) retire_cnt <= retire_cnt + 64'd1;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Payload storage carries no reset; validity lives in count/pointers.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && push) mem[wr_ptr] <= new_ent;
  end

  assign head        = mem[rd_ptr];
  assign trace_valid = !empty;
  assign trace_pc    = empty ? 64'd0 : head.pc;
  assign trace_we    = empty ? 1'b0  : head.we;
  assign trace_wnum  = empty ? 5'd0  : head.wnum;
  assign trace_wdata = empty ? 64'd0 : head.wdata;
  assign fifo_count  = count;

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0, wb_stall = 1'b0, clear = 1'b0, trace_ready = 1'b0;
  logic [63:0] pc = '0, wdata = '0;
  logic [7:0]  rfwe = '0;
  logic [4:0]  wnum = '0;
  logic        trace_valid, trace_we, overflow;
  logic [63:0] trace_pc, trace_wdata, retire_cnt;
  logic [4:0]  trace_wnum;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0] drop_cnt;

  commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall), .clear(clear),
    .debug_wb_pc(pc), .debug_wb_rf_we(rfwe), .debug_wb_rf_wnum(wnum),
    .debug_wb_rf_wdata(wdata), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_we(trace_we), .trace_wnum(trace_wnum),
    .trace_wdata(trace_wdata), .fifo_count(fifo_count), .overflow(overflow),
    .drop_cnt(drop_cnt), .retire_cnt(retire_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        we;
    logic [4:0]  wnum;
    logic [63:0] wdata;
  } ent_t;

  // Reference model: a plain queue of expected entries plus counters.
  ent_t        q[$];
  logic [63:0] m_retire;
  int          m_drop;
  logic        m_ovf;
  bit          mon_en = 1'b0;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one clock edge to the model using the inputs held across it.
  // The monitor has already removed the entry popped at this edge.
  task automatic cyc();
    bit ret, we, want;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); m_retire = '0; m_drop = 0; m_ovf = 1'b0;
    end else begin
      ret  = (pc != 0) && !wb_stall;
      we   = rfwe[0] && (wnum != 0);
`ifdef TRACE_WRONLY_EN
      want = ret && we;
`else
      want = ret;
`endif
      if (ret) m_retire = m_retire + 1;
      if (clear) q.delete();
      else if (want) begin
        if (q.size() < DEPTH) begin
          e.pc = pc; e.we = we; e.wnum = wnum; e.wdata = wdata;
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < (1 << CNT_W) - 1) m_drop++;
        end
      end
    end
    #1;
  endtask

  // Scoreboard monitor: compares the DUT against the model between edges
  // and retires the head entry when a handshake will complete.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", 64'(trace_valid), 64'(q.size() != 0));
      chk("count", 64'(fifo_count), 64'(q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("retire_cnt", retire_cnt, m_retire);
      if (q.size() != 0) begin
        chk("pc", trace_pc, q[0].pc);
        chk("we", 64'(trace_we), 64'(q[0].we));
        chk("wnum", 64'(trace_wnum), 64'(q[0].wnum));
        chk("wdata", trace_wdata, q[0].wdata);
        if (trace_ready) void'(q.pop_front());
      end else begin
        chk("empty_payload", trace_pc | trace_wdata | 64'(trace_wnum) | 64'(trace_we), 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    pc = '0; wb_stall = 1'b0; clear = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic retire_one(input logic [63:0] p, input logic [4:0] n);
    pc = p; wnum = n; rfwe = 8'h01; wdata = {$urandom, $urandom}; wb_stall = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pc = '0; clear = 1'b0; wb_stall = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    mon_en = 1'b1;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_retire", retire_cnt, 64'd0);

    // Three retires drained in order.
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) retire_one(64'h8000_0000 + 64'(4 * i), 5'(i + 1));
    idle(4);
    chk("s1_retire", retire_cnt, 64'd3);
    chk("s1_count", 64'(fifo_count), 64'd0);

    // Bubbles, then one entry held through a stall.
    do_reset();
    trace_ready = 1'b0;
    idle(5);
    pc = 64'h100; wnum = 5'd7; rfwe = 8'h01; wdata = 64'hABCD;
    wb_stall = 1'b1; repeat (3) cyc();
    wb_stall = 1'b0; cyc();
    idle(1);
    chk("s2_retire", retire_cnt, 64'd1);
    chk("s2_count", 64'(fifo_count), 64'd1);
    trace_ready = 1'b1; idle(2);

    // Write to x0.
    do_reset();
    pc = 64'h200; wnum = 5'd0; rfwe = 8'hFF; wdata = 64'h55; cyc();
    trace_ready = 1'b0; idle(1);
    chk("s3_retire", retire_cnt, 64'd1);
`ifdef TRACE_WRONLY_EN
    chk("s3_count", 64'(fifo_count), 64'd0);
`else
    chk("s3_we", 64'(trace_we), 64'd0);
    chk("s3_valid", 64'(trace_valid), 64'd1);
`endif
    trace_ready = 1'b1; idle(2);

    // Overflow: DEPTH+3 retires with consumer stalled.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) retire_one(64'h1000 + 64'(4 * i), 5'(i % 31 + 1));
    idle(1);
    chk("s4_count", 64'(fifo_count), 64'(DEPTH));
    chk("s4_ovf", 64'(overflow), 64'd1);
    chk("s4_drop", 64'(drop_cnt), 64'd3);
    trace_ready = 1'b1; idle(DEPTH + 2);

    // Full FIFO: push and pop together.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) retire_one(64'h2000 + 64'(4 * i), 5'd9);
    trace_ready = 1'b1;
    retire_one(64'h2F00, 5'd10);
    chk("s5_count", 64'(fifo_count), 64'(DEPTH));
    chk("s5_drop", 64'(drop_cnt), 64'd0);
    idle(DEPTH + 2);

    // Clear together with a retire.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) retire_one(64'h3000 + 64'(4 * i), 5'd4);
    clear = 1'b1; retire_one(64'h3100, 5'd5);
    clear = 1'b0; pc = '0;
    chk("s6_count", 64'(fifo_count), 64'd0);
    chk("s6_valid", 64'(trace_valid), 64'd0);
    chk("s6_retire", retire_cnt, 64'd6);
    chk("s6_ovf", 64'(overflow), 64'd0);

    // Reset in the middle of a drain after an overflow.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) retire_one(64'h4000 + 64'(4 * i), 5'd6);
    trace_ready = 1'b1; idle(3);
    do_reset();
    chk("s7_valid", 64'(trace_valid), 64'd0);
    chk("s7_pc", trace_pc, 64'd0);
    chk("s7_count", 64'(fifo_count), 64'd0);
    chk("s7_ovf", 64'(overflow), 64'd0);
    chk("s7_drop", 64'(drop_cnt), 64'd0);
    chk("s7_retire", retire_cnt, 64'd0);

    // Randomized traffic with phases of slow and fast consumers.
    for (int i = 0; i < 3000; i++) begin
      pc       = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
      wb_stall = ($urandom_range(0, 3) == 0);
      clear    = ($urandom_range(0, 60) == 0);
      rfwe     = 8'($urandom);
      wnum     = 5'($urandom);
      wdata    = {$urandom, $urandom};
      trace_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 4) == 0)
                                         : ($urandom_range(0, 3) != 0);
      cyc();
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
